// File: rtl/evm_pkg.sv
// Shared EVM definitions: the scan FSM state encoding and the default count-register geometry,
// used by both the tally reader and the count register writer.
package evm_pkg;

    localparam int DEF_NUM_CAND = 4;
    localparam int DEF_DATA_W   = 4;
    localparam int DEF_IDX_W    = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_SEND   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/max_tracker.sv
// Running-maximum tracker for the tally scan: keeps the max count, the lowest index holding it,
// and whether that maximum has been seen more than once.
module max_tracker
    import evm_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IDX_W  = DEF_IDX_W
)(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic [IDX_W-1:0]  i_idx,
    output logic [IDX_W-1:0]  o_win,
    output logic              o_tie
);

    logic [DATA_W-1:0] r_max;
    logic [IDX_W-1:0]  r_win;
    logic              r_tie;
    logic              w_first;

    assign w_first = (i_idx == '0);

    // Index 0 seeds the max unconditionally; only a strictly greater count moves the winner,
    // so the lowest index holding the maximum is kept.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_max <= '0;
            r_win <= '0;
            r_tie <= 1'b0;
        end else if (i_load) begin
            if (w_first || (i_data > r_max)) begin
                r_max <= i_data;
                r_win <= i_idx;
                r_tie <= 1'b0;
            end else if (i_data == r_max) begin
                r_tie <= 1'b1;
            end
        end
    end

    assign o_win = r_win;
    assign o_tie = r_tie;

endmodule

// File: rtl/vote_tally_reader.sv
// Scans the per-candidate count registers, streams (candidate, count) pairs over valid/ready and
// reports winner/tie at scan end. Define VOTE_TALLY_TOTAL_EN to add the o_total vote-sum output.
module vote_tally_reader
    import evm_pkg::*;
#(
    parameter int NUM_CAND = DEF_NUM_CAND,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int IDX_W    = DEF_IDX_W
)(
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    output logic [IDX_W-1:0]        o_rd_addr,
    input  logic [DATA_W-1:0]       i_rd_data,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic [IDX_W-1:0]        o_out_cand,
    output logic [DATA_W-1:0]       o_out_count,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [IDX_W-1:0]        o_winner,
    output logic                    o_tie
`ifdef VOTE_TALLY_TOTAL_EN
    ,
    output logic [DATA_W+IDX_W-1:0] o_total
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

    state_t            r_state;
    logic [IDX_W-1:0]  r_rd_addr;
    logic              r_out_valid;
    logic [IDX_W-1:0]  r_out_cand;
    logic [DATA_W-1:0] r_out_count;
    logic              r_busy;
    logic              r_done;
    logic [IDX_W-1:0]  r_winner;
    logic              r_tie;

    logic              w_scan_start;
    logic              w_fetch;
    logic [IDX_W-1:0]  w_trk_win;
    logic              w_trk_tie;

`ifdef VOTE_TALLY_TOTAL_EN
    logic [DATA_W+IDX_W-1:0] r_acc;
    logic [DATA_W+IDX_W-1:0] r_total;
`endif

    assign w_scan_start = (r_state == ST_IDLE) && i_start;
    assign w_fetch      = (r_state == ST_FETCH);

    max_tracker #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_max_tracker (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (w_scan_start),
        .i_load  (w_fetch),
        .i_data  (i_rd_data),
        .i_idx   (r_rd_addr),
        .o_win   (w_trk_win),
        .o_tie   (w_trk_tie)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_rd_addr   <= '0;
            r_out_valid <= 1'b0;
            r_out_cand  <= '0;
            r_out_count <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_winner    <= '0;
            r_tie       <= 1'b0;
`ifdef VOTE_TALLY_TOTAL_EN
            r_acc       <= '0;
            r_total     <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_rd_addr <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_FETCH;
`ifdef VOTE_TALLY_TOTAL_EN
                        r_acc     <= '0;
`endif
                    end
                end
                ST_FETCH: begin
                    r_out_count <= i_rd_data;
                    r_out_cand  <= r_rd_addr;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_SEND;
`ifdef VOTE_TALLY_TOTAL_EN
                    r_acc       <= r_acc + (DATA_W+IDX_W)'(i_rd_data);
`endif
                end
                ST_SEND: begin
                    // Pair stays frozen until the sink takes it; the address only advances afterwards.
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_out_cand == LAST_IDX) begin
                            r_state <= ST_FINISH;
                        end else begin
                            r_rd_addr <= r_rd_addr + 1'b1;
                            r_state   <= ST_FETCH;
                        end
                    end
                end
                ST_FINISH: begin
                    r_winner <= w_trk_win;
                    r_tie    <= w_trk_tie;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
`ifdef VOTE_TALLY_TOTAL_EN
                    r_total  <= r_acc;
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_rd_addr   = r_rd_addr;
    assign o_out_valid = r_out_valid;
    assign o_out_cand  = r_out_cand;
    assign o_out_count = r_out_count;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_winner    = r_winner;
    assign o_tie       = r_tie;
`ifdef VOTE_TALLY_TOTAL_EN
    assign o_total     = r_total;
`endif

endmodule

// File: tb/tb_vote_tally_reader.sv
// Bench for vote_tally_reader: directed and randomized scans against a behavioural tally model.
// Builds with or without VOTE_TALLY_TOTAL_EN.
module tb_vote_tally_reader;

    localparam int N  = 4;
    localparam int DW = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          ready;
    logic [IW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          valid;
    logic [IW-1:0] cand;
    logic [DW-1:0] count;
    logic          busy;
    logic          done;
    logic [IW-1:0] winner;
    logic          tie;
`ifdef VOTE_TALLY_TOTAL_EN
    logic [DW+IW-1:0] total;
`endif

    logic [DW-1:0] mem [N];
    int cyc = 0;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign rd_data = mem[rd_addr];

    vote_tally_reader #(.NUM_CAND(N), .DATA_W(DW), .IDX_W(IW)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .o_rd_addr   (rd_addr),
        .i_rd_data   (rd_data),
        .o_out_valid (valid),
        .i_out_ready (ready),
        .o_out_cand  (cand),
        .o_out_count (count),
        .o_busy      (busy),
        .o_done      (done),
        .o_winner    (winner),
        .o_tie       (tie)
`ifdef VOTE_TALLY_TOTAL_EN
        ,
        .o_total     (total)
`endif
    );

    task automatic set_mem(input int a, input int b, input int c, input int d);
        mem[0] = DW'(a); mem[1] = DW'(b); mem[2] = DW'(c); mem[3] = DW'(d);
    endtask

    // One full scan. stall_k/stall_len: hold ready low on that pair; restart_k: pulse start while
    // that pair is shown; fin_start: pulse start during the FINISH cycle.
    task automatic run_scan(input string nm, input int stall_k, input int stall_len,
                            input bit rand_ready, input int restart_k, input bit fin_start);
        int exp_m, exp_w, nmax, exp_sum, s, k, seen, stalls, sc, hs_edge;
        bit got_done, rs_done;
        exp_m = -1; exp_w = 0; nmax = 0; exp_sum = 0;
        for (int i = 0; i < N; i++) begin
            exp_sum += int'(mem[i]);
            if (int'(mem[i]) > exp_m) begin exp_m = int'(mem[i]); exp_w = i; end
        end
        for (int i = 0; i < N; i++) if (int'(mem[i]) == exp_m) nmax++;

        @(negedge clk); start = 1'b1; ready = 1'b1;
        @(negedge clk); start = 1'b0; s = cyc;
        k = 0; seen = -1; stalls = 0; sc = 0; hs_edge = 0; got_done = 0; rs_done = 0;
        for (int t = 0; t < 300; t++) begin
            if (done) begin
                got_done = 1;
                n_tests++;
                if (cyc - s !== 2*N + 1 + stalls) begin
                    n_fail++; $display("FAIL %s done_latency: got %0d want %0d", nm, cyc - s, 2*N + 1 + stalls);
                end
                n_tests++;
                if (k !== N) begin n_fail++; $display("FAIL %s pair_count: got %0d want %0d", nm, k, N); end
                n_tests++;
                if (winner !== IW'(exp_w) || tie !== (nmax >= 2) || busy !== 1'b0) begin
                    n_fail++; $display("FAIL %s result: winner %0d tie %0b busy %0b want %0d %0b 0",
                                       nm, winner, tie, busy, exp_w, nmax >= 2);
                end
`ifdef VOTE_TALLY_TOTAL_EN
                n_tests++;
                if (total !== (DW+IW)'(exp_sum)) begin
                    n_fail++; $display("FAIL %s total: got %0d want %0d", nm, total, exp_sum);
                end
`endif
                break;
            end
            n_tests++;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL %s busy: got %0b want 1 at cyc %0d", nm, busy, cyc - s); end
            if (valid) begin
                n_tests++;
                if (k >= N) begin
                    n_fail++; $display("FAIL %s extra_pair: cand %0d", nm, cand);
                end else if (cand !== IW'(k) || count !== mem[k] || rd_addr !== IW'(k)) begin
                    n_fail++; $display("FAIL %s pair%0d: cand %0d count %0d addr %0d want %0d %0d %0d",
                                       nm, k, cand, count, rd_addr, k, mem[k], k);
                end
                if (seen != k) begin
                    n_tests++;
                    if ((k == 0) ? (cyc - s != 1) : (cyc != hs_edge + 1)) begin
                        n_fail++; $display("FAIL %s pair%0d_timing: at cyc %0d (start %0d, hs %0d)", nm, k, cyc, s, hs_edge);
                    end
                    seen = k;
                end
            end
            start = 1'b0;
            if (restart_k >= 0 && valid && k == restart_k && !rs_done) begin start = 1'b1; rs_done = 1; end
            if (fin_start && !valid && k == N) start = 1'b1;
            if (rand_ready) ready = 1'($urandom_range(0, 1));
            else ready = !(valid && k == stall_k && sc < stall_len);
            if (valid && !ready) begin stalls++; if (k == stall_k) sc++; end
            if (valid && ready) begin hs_edge = cyc + 1; k++; end
            @(negedge clk);
        end
        start = 1'b0;
        if (!got_done) begin n_tests++; n_fail++; $display("FAIL %s timeout: no done", nm); end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0 || winner !== IW'(exp_w) || tie !== (nmax >= 2)) begin
            n_fail++; $display("FAIL %s hold: done %0b busy %0b winner %0d tie %0b", nm, done, busy, winner, tie);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; ready = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (valid !== 0 || busy !== 0 || done !== 0 || winner !== 0 || tie !== 0 ||
            rd_addr !== 0 || cand !== 0 || count !== 0) begin
            n_fail++; $display("FAIL reset: valid %0b busy %0b done %0b winner %0d tie %0b addr %0d cand %0d count %0d",
                               valid, busy, done, winner, tie, rd_addr, cand, count);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        set_mem(3, 7, 2, 5);
        run_scan("basic", -1, 0, 0, -1, 0);
    endtask

    task automatic test_tie();
        set_mem(6, 2, 6, 1);
        run_scan("tie", -1, 0, 0, -1, 0);
    endtask

    task automatic test_zero_and_max();
        set_mem(0, 0, 0, 0);
        run_scan("zeros", -1, 0, 0, -1, 0);
        set_mem(15, 0, 0, 15);
        run_scan("max15", -1, 0, 0, -1, 0);
    endtask

    task automatic test_stall();
        set_mem(3, 7, 2, 5);
        run_scan("stall", 1, 5, 0, -1, 0);
    endtask

    task automatic test_restart_ignored();
        set_mem(4, 9, 9, 1);
        run_scan("restart_mid", -1, 0, 0, 2, 0);
        set_mem(1, 2, 3, 8);
        run_scan("start_at_finish", -1, 0, 0, -1, 1);
    endtask

    task automatic test_rst_mid();
        bit hit;
        set_mem(3, 7, 2, 5);
        run_scan("pre_rst", -1, 0, 0, -1, 0);
        @(negedge clk); start = 1'b1; ready = 1'b1;
        @(negedge clk); start = 1'b0;
        hit = 0;
        for (int t = 0; t < 50; t++) begin
            if (valid && cand == 2'd2) begin hit = 1; ready = 1'b0; break; end
            @(negedge clk);
        end
        n_tests++;
        if (!hit) begin n_fail++; $display("FAIL rst_mid reach_pair2: got none want pair 2"); end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        n_tests++;
        if (valid !== 0 || busy !== 0 || winner !== 0 || tie !== 0 || rd_addr !== 0 || done !== 0) begin
            n_fail++; $display("FAIL rst_mid: valid %0b busy %0b winner %0d tie %0b addr %0d done %0b want all 0",
                               valid, busy, winner, tie, rd_addr, done);
        end
        run_scan("post_rst", -1, 0, 0, -1, 0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            int hi;
            hi = (it % 2 == 0) ? 15 : 2;
            for (int i = 0; i < N; i++) mem[i] = DW'($urandom_range(0, hi));
            run_scan("random", -1, 0, 1, -1, 0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_zero_and_max();
        test_stall();
        test_restart_ignored();
        test_rst_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
